// File: rtl/apb_requester.sv
`default_nettype none
// apb_requester: turns single-beat commands into APB3 SETUP/ACCESS transfers,
// returns a one-cycle response and aborts transfers that stall too long.
module apb_requester #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [9:0]  cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic [9:0]  paddr_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nx, wait_inc;
  logic              ready_nx, psel_nx, penable_nx, pwrite_nx;
  logic              rsp_valid_nx, rsp_err_nx;
  logic [9:0]        paddr_nx;
  logic [31:0]       pwdata_nx, rsp_rdata_nx;

  // Saturating increment so a disabled timeout can never wrap the counter.
  assign wait_inc = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready_o <= 1'b1;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      paddr_o     <= '0;
      pwrite_o    <= 1'b0;
      pwdata_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_cnt_nx;
      cmd_ready_o <= ready_nx;
      psel_o      <= psel_nx;
      penable_o   <= penable_nx;
      paddr_o     <= paddr_nx;
      pwrite_o    <= pwrite_nx;
      pwdata_o    <= pwdata_nx;
      rsp_valid_o <= rsp_valid_nx;
      rsp_rdata_o <= rsp_rdata_nx;
      rsp_err_o   <= rsp_err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    wait_cnt_nx  = wait_cnt;
    ready_nx     = cmd_ready_o;
    psel_nx      = psel_o;
    penable_nx   = penable_o;
    paddr_nx     = paddr_o;
    pwrite_nx    = pwrite_o;
    pwdata_nx    = pwdata_o;
    rsp_valid_nx = 1'b0;
    rsp_rdata_nx = rsp_rdata_o;
    rsp_err_nx   = rsp_err_o;

    case (state)
      IDLE: begin
        ready_nx   = 1'b1;
        psel_nx    = 1'b0;
        penable_nx = 1'b0;
        if (cmd_valid_i && cmd_ready_o) begin
          paddr_nx    = cmd_addr_i;
          pwrite_nx   = cmd_write_i;
          pwdata_nx   = cmd_write_i ? cmd_wdata_i : 32'd0;
          psel_nx     = 1'b1;
          ready_nx    = 1'b0;
          wait_cnt_nx = '0;
          state_nx    = SETUP;
        end
      end

      SETUP: begin
        penable_nx = 1'b1;
        state_nx   = ACCESS;
      end

      ACCESS: begin
        if (pready_i) begin
          psel_nx      = 1'b0;
          penable_nx   = 1'b0;
          ready_nx     = 1'b1;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = 1'b0;
          rsp_rdata_nx = pwrite_o ? 32'd0 : prdata_i;
          state_nx     = IDLE;
        end else begin
          wait_cnt_nx = wait_inc;
          // This low-ready cycle is the TIMEOUT_CYCLES-th one: abort now.
          if (TIMEOUT_EN && (wait_inc >= LIMIT)) begin
            psel_nx      = 1'b0;
            penable_nx   = 1'b0;
            ready_nx     = 1'b1;
            rsp_valid_nx = 1'b1;
            rsp_err_nx   = 1'b1;
            rsp_rdata_nx = 32'd0;
            state_nx     = IDLE;
          end
        end
      end

      default: begin
        psel_nx    = 1'b0;
        penable_nx = 1'b0;
        ready_nx   = 1'b1;
        state_nx   = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
